// File: rtl/divider.sv
// Iterative unsigned restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready_o high
//  CALC  | shifting/subtracting, one quotient bit per clock
//  DONE  | result presented, out_valid_o high until out_ready_i
module divider #(
  parameter int unsigned OperandWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [2*OperandWidth-1:0]   dividend_i,
  input  logic [OperandWidth-1:0]     divisor_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OperandWidth-1:0]     quotient_o,
  output logic [OperandWidth-1:0]     remainder_o,
  output logic                        overflow_o
);

  localparam int unsigned W  = OperandWidth;
  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CntLast = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  dvd_hi;
  logic [W-1:0]  dvd_lo;
  logic [W:0]    trial;
  logic [W:0]    d_ext;

  assign dvd_hi = dividend_i[2*W-1:W];
  assign dvd_lo = dividend_i[W-1:0];
  // The top remainder bit is always zero outside the trial, so only W bits are stored.
  assign trial  = {r_q, q_q[W-1]};
  assign d_ext  = {1'b0, d_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          d_d   = divisor_i;
          cnt_d = '0;
          // Upper half >= divisor means the quotient needs more than W bits (covers /0).
          if (dvd_hi >= divisor_i) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
          end else begin
            state_d = CALC;
            ovf_d   = 1'b0;
            r_d     = dvd_hi;
            q_d     = dvd_lo;
          end
        end
      end
      CALC: begin
        if (trial >= d_ext) begin
          r_d = W'(trial - d_ext);
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = trial[W-1:0];
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign quotient_o  = q_q;
  assign remainder_o = r_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider (W=32): normal, overflow, backpressure and
// mid-operation reset cases against hand-computed results.
module tb_divider;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        overflow_o;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  divider #(.OperandWidth(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 in IDLE; returns edges from acceptance to out_valid_o.
  task automatic launch(input logic [63:0] dvd, input logic [31:0] dvs, output int l);
    in_valid_i = 1'b1;
    dividend_i = dvd;
    divisor_i  = dvs;
    chk("ready_before_accept", in_ready_o, 1'b1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    l = 0;
    while (!out_valid_o && l < 100) begin
      @(posedge clk_i); #1;
      l++;
    end
  endtask

  task automatic release_result();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    chk("ready_after_release", in_ready_o, 1'b1);
    chk("valid_after_release", out_valid_o, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_quotient", quotient_o, 32'd0);
    chk("rst_remainder", remainder_o, 32'd0);
    chk("rst_overflow", overflow_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 100 / 7
    launch(64'd100, 32'd7, lat);
    chk("lat_100_7", lat, 32);
    chk("q_100_7", quotient_o, 32'd14);
    chk("r_100_7", remainder_o, 32'd2);
    chk("ovf_100_7", overflow_o, 1'b0);
    release_result();

    // (2^32-1)^2 / (2^32-1)
    launch(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, lat);
    chk("lat_max", lat, 32);
    chk("q_max", quotient_o, 32'hFFFF_FFFF);
    chk("r_max", remainder_o, 32'd0);
    chk("ovf_max", overflow_o, 1'b0);
    release_result();

    // divide by zero
    launch(64'd123, 32'd0, lat);
    chk("lat_div0", lat, 0);
    chk("ovf_div0", overflow_o, 1'b1);
    chk("q_div0", quotient_o, 32'hFFFF_FFFF);
    chk("r_div0", remainder_o, 32'd0);
    release_result();

    // upper half equal to divisor
    launch(64'h0000_0005_0000_0000, 32'd5, lat);
    chk("lat_ovf5", lat, 0);
    chk("ovf_ovf5", overflow_o, 1'b1);
    chk("q_ovf5", quotient_o, 32'hFFFF_FFFF);
    release_result();

    // backpressure with competing operands
    launch(64'd1000, 32'd10, lat);
    chk("lat_bp", lat, 32);
    in_valid_i = 1'b1;
    dividend_i = 64'd999;
    divisor_i  = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      chk("bp_valid", out_valid_o, 1'b1);
      chk("bp_ready", in_ready_o, 1'b0);
      chk("bp_q", quotient_o, 32'd100);
      chk("bp_r", remainder_o, 32'd0);
    end
    in_valid_i = 1'b0;
    release_result();

    // out_ready_i held high: DONE lasts exactly one cycle
    out_ready_i = 1'b1;
    launch(64'd50, 32'd6, lat);
    chk("lat_hold", lat, 32);
    chk("q_hold", quotient_o, 32'd8);
    chk("r_hold", remainder_o, 32'd2);
    @(posedge clk_i); #1;
    chk("hold_valid_drop", out_valid_o, 1'b0);
    chk("hold_ready", in_ready_o, 1'b1);
    out_ready_i = 1'b0;

    // reset during CALC step 10
    in_valid_i = 1'b1;
    dividend_i = 64'd1000;
    divisor_i  = 32'd10;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    chk("pre_rst_busy", in_ready_o, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready_o, 1'b1);
    chk("mid_rst_valid", out_valid_o, 1'b0);
    chk("mid_rst_q", quotient_o, 32'd0);
    chk("mid_rst_r", remainder_o, 32'd0);
    chk("mid_rst_ovf", overflow_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_no_result", out_valid_o, 1'b0);

    launch(64'd77, 32'd8, lat);
    chk("lat_77_8", lat, 32);
    chk("q_77_8", quotient_o, 32'd9);
    chk("r_77_8", remainder_o, 32'd5);
    chk("ovf_77_8", overflow_o, 1'b0);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Iterative unsigned restoring divider, the inverse of the team's generic multiplier. It takes a 2*OperandWidth dividend (a full multiplier product) and an OperandWidth divisor, and returns an OperandWidth quotient and remainder. It resolves one quotient bit per clock and uses a valid/ready handshake on both input and output. It sits beside the multiplier in COMP.CE.250 arithmetic datapaths.

Parameters:
OperandWidth, 32, width of divisor, quotient and remainder; dividend is 2*OperandWidth; legal range >= 2.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
in_valid_i  input  1  operands valid
in_ready_o  output  1  divider can accept operands
dividend_i  input  2*OperandWidth  unsigned dividend
divisor_i  input  OperandWidth  unsigned divisor
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
quotient_o  output  OperandWidth  unsigned quotient
remainder_o  output  OperandWidth  unsigned remainder
overflow_o  output  1  quotient does not fit, or divisor is zero

Behaviour:
- One clock, clk_i; reset is asynchronous and active-low on rst_ni; all flops clear immediately on rst_ni low.
- Reset values: state IDLE, so in_ready_o=1; out_valid_o=0, quotient_o=0, remainder_o=0, overflow_o=0; counter=0.
- FSM states are IDLE, CALC and DONE. in_ready_o=1 only in IDLE; out_valid_o=1 only in DONE.
- IDLE: on an edge with in_valid_i & in_ready_o, capture divisor D, R={1'b0, dividend_i[2W-1:W]} (W+1 bits), Q=dividend_i[W-1:0], counter=0.
  - If dividend_i[2W-1:W] >= divisor_i (this includes divisor_i==0), go to DONE with overflow=1, quotient='1, remainder='0.
  - Otherwise go to CALC with overflow=0.
- CALC: one step per edge.
  - T={R[W-1:0], Q[W-1]}.
  - If T >= D: R=T-D and Q={Q[W-2:0],1}.
  - Else: R=T and Q={Q[W-2:0],0}.
  - counter++. After the step with counter==W-1, go to DONE.
  - R never exceeds W bits after a step, given the no-overflow precondition.
- DONE: quotient_o=Q, remainder_o=R[W-1:0], overflow_o as captured. Hold until an edge with out_ready_i=1, then return to IDLE.
- Latency: if acceptance is at edge E, out_valid_o rises after edge E+W in the normal case, and after edge E in the overflow case.
- Throughput: one operation per W+2 cycles minimum. No acceptance is possible in the same cycle as a result handshake.
- Outputs are stable while out_valid_o=1 and out_ready_i=0. quotient_o, remainder_o and overflow_o are meaningful only while out_valid_o=1.
- Input signals are ignored outside IDLE; in_valid_i held high during CALC/DONE has no effect.
- in_valid_i may drop without handshake in IDLE; nothing is captured.
- Reset asserted mid-CALC or in DONE aborts the operation; no result is ever emitted for it.
- out_ready_i may be held high permanently; DONE then lasts exactly one cycle.

Test Plan:
- W=32; dividend 64'd100, divisor 7 -> quotient 14, remainder 2, overflow 0; out_valid_o rises exactly 32 edges after acceptance.
- Dividend 64'hFFFF_FFFE_0000_0001, divisor 32'hFFFF_FFFF -> quotient 32'hFFFF_FFFF, remainder 0, overflow 0.
- Divisor 0, dividend 64'd123 -> overflow 1, quotient 32'hFFFF_FFFF, remainder 0; out_valid_o high in the cycle after acceptance.
- Dividend 64'h0000_0005_0000_0000, divisor 5 -> overflow 1, and no CALC cycles occur.
- Backpressure: dividend 64'd1000, divisor 10 with out_ready_i=0 for 10 cycles after out_valid_o -> quotient 100 and remainder 0 stay stable, in_ready_o stays 0, and differing operands driven with in_valid_i=1 are ignored. On release, in_ready_o=1 the next cycle.
- Reset mid-operation: pulse rst_ni low during CALC step 10 -> all outputs are at reset values immediately and in_ready_o=1. Then 64'd77 / 8 completes with quotient 9, remainder 5.
